// File: rtl/posit_defines_es3.sv
// Shared definitions for the ES3 posit datapath (raw adder and normalizer).
// Holds the serialized raw-sum layout, the posit<32,3> geometry and the
// special encodings used when packing a raw sum into a posit.
package posit_defines_es3;

  localparam int POSIT_SERIALIZED_WIDTH_SUM_ES3 = 41;
  localparam int ABITS                          = 29;

  localparam int          POSIT_WIDTH_ES3    = 32;
  localparam int          POSIT_ES3          = 3;
  localparam int          POSIT_MAXSCALE_ES3 = 240;
  localparam logic [31:0] POSIT_NAR_ES3      = 32'h80000000;
  localparam logic [31:0] POSIT_MAXPOS_ES3   = 32'h7FFFFFFF;
  localparam logic [31:0] POSIT_MINPOS_ES3   = 32'h00000001;

  // Raw sum as produced by the adder: fraction has an implicit hidden bit,
  // its MSB weighs 2^-1.
  typedef struct packed {
    logic                    sgn;
    logic signed [8:0]       scale;
    logic [ABITS-1:0]        fraction;
    logic                    inf;
    logic                    zero;
  } value_sum;

endpackage

// File: rtl/shift_right.sv
// Generic logical right shifter (zero fill).
// Ports:
//   i_data  : N-bit operand
//   i_shamt : S-bit shift amount
//   o_data  : i_data >> i_shamt
module shift_right #(
  parameter int N = 64,
  parameter int S = 6
) (
  input  logic [N-1:0] i_data,
  input  logic [S-1:0] i_shamt,
  output logic [N-1:0] o_data
);

  assign o_data = i_data >> i_shamt;

endmodule

// File: rtl/posit_normalize_es3.sv
// Packs the ES3 raw adder's serialized sum into a posit<32,3> with
// round-to-nearest-even and saturation to maxpos/minpos. Fixed 3-cycle
// latency, one operand per cycle, no back-pressure.
// Ports:
//   clk          : clock, all state on rising edge
//   reset        : synchronous active-high reset
//   in1          : raw sum {sgn, scale[8:0], fraction[28:0], inf, zero}
//   truncated_in : sticky flag, nonzero bits lost upstream
//   start        : in1/truncated_in valid this cycle
//   result       : posit<32,3>, holds its value while done is low
//   done         : result valid this cycle (start delayed by 3 cycles)
module posit_normalize_es3
  import posit_defines_es3::*;
(
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [POSIT_SERIALIZED_WIDTH_SUM_ES3-1:0] in1,
  input  logic                                      truncated_in,
  input  logic                                      start,
  output logic [POSIT_WIDTH_ES3-1:0]                result,
  output logic                                      done
);

  localparam logic signed [8:0] SCALE_MAX = 9'(POSIT_MAXSCALE_ES3);
  localparam logic signed [8:0] SCALE_MIN = 9'(-POSIT_MAXSCALE_ES3);

  // Clamp out-of-range scales before rounding; the clamped bodies carry no
  // round bits so they can never step past maxpos or down to zero.
  function automatic logic [32:0] saturate(
    input logic signed [8:0] scale,
    input logic [30:0]       body,
    input logic              g,
    input logic              s
  );
    if (scale >= SCALE_MAX)
      return {POSIT_MAXPOS_ES3[30:0], 2'b00};
    if (scale < SCALE_MIN)
      return {POSIT_MINPOS_ES3[30:0], 2'b00};
    return {body, g, s};
  endfunction

  function automatic logic [31:0] round_rne(
    input logic [30:0] body,
    input logic        g,
    input logic        s
  );
    return {1'b0, body} + {31'b0, g & (body[0] | s)};
  endfunction

  // ---- Stage 0: capture operand ----
  value_sum r_val_p0;
  logic     r_trunc_p0;
  logic     r_vld_p0;

  always_ff @(posedge clk) begin
    if (reset) r_vld_p0 <= 1'b0;
    else       r_vld_p0 <= start;
  end

  always_ff @(posedge clk) begin
    r_val_p0   <= value_sum'(in1);
    r_trunc_p0 <= truncated_in;
  end

  // ---- Stage 1: regime placement, body extraction, g/s ----
  logic signed [5:0] w_k_p1;
  logic              w_kneg_p1;
  logic [5:0]        w_shamt_p1;
  logic [63:0]       w_src_p1;
  logic [63:0]       w_shifted_p1;
  logic [63:0]       w_field_p1;

  // k = scale >>> 3 is exactly the top six scale bits.
  assign w_k_p1     = r_val_p0.scale[8:3];
  assign w_kneg_p1  = w_k_p1[5];
  assign w_shamt_p1 = w_kneg_p1 ? 6'(-w_k_p1) : 6'(w_k_p1 + 6'sd1);

  // Negative k: shift {1,e,frac} right so -k zeros precede the terminating 1.
  // Positive k: shift the complement so the zero fill becomes k+1 ones after
  // re-inverting, with the terminating 0 landing right behind them.
  assign w_src_p1 = w_kneg_p1
                  ?  {1'b1, r_val_p0.scale[2:0], r_val_p0.fraction, 31'b0}
                  : ~{1'b0, r_val_p0.scale[2:0], r_val_p0.fraction, 31'b0};

  shift_right #(
    .N(64),
    .S(6)
  ) u_regime_shift (
    .i_data (w_src_p1),
    .i_shamt(w_shamt_p1),
    .o_data (w_shifted_p1)
  );

  assign w_field_p1 = w_kneg_p1 ? w_shifted_p1 : ~w_shifted_p1;

  logic [30:0] r_body_p1;
  logic        r_g_p1;
  logic        r_s_p1;
  logic        r_sgn_p1;
  logic        r_nar_p1;
  logic        r_vld_p1;

  always_ff @(posedge clk) begin
    if (reset) r_vld_p1 <= 1'b0;
    else       r_vld_p1 <= r_vld_p0;
  end

  always_ff @(posedge clk) begin
    if (r_val_p0.zero)
      {r_body_p1, r_g_p1, r_s_p1} <= 33'b0;
    else
      {r_body_p1, r_g_p1, r_s_p1} <= saturate(r_val_p0.scale,
                                              w_field_p1[63:33],
                                              w_field_p1[32],
                                              (|w_field_p1[31:0]) | r_trunc_p0);
    r_sgn_p1 <= r_val_p0.sgn & ~r_val_p0.zero & ~r_val_p0.inf;
    r_nar_p1 <= r_val_p0.inf;
  end

  // ---- Stage 2: round, apply sign, register result ----
  logic [31:0] w_mag_p2;
  logic [31:0] w_res_p2;

  assign w_mag_p2 = round_rne(r_body_p1, r_g_p1, r_s_p1);
  assign w_res_p2 = r_nar_p1 ? POSIT_NAR_ES3
                  : (r_sgn_p1 ? -w_mag_p2 : w_mag_p2);

  logic [31:0] r_result_p2;
  logic        r_vld_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p2    <= 1'b0;
      r_result_p2 <= '0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) r_result_p2 <= w_res_p2;
    end
  end

  assign result = r_result_p2;
  assign done   = r_vld_p2;

endmodule

// File: tb/tb_posit_normalize_es3.sv
// Directed bench for posit_normalize_es3: hand-computed encodings streamed
// back-to-back and with gaps, then a reset that kills in-flight operands.
module tb_posit_normalize_es3;

  localparam int NV = 17;

  logic        clk;
  logic        reset;
  logic [40:0] in1;
  logic        truncated_in;
  logic        start;
  logic [31:0] result;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  posit_normalize_es3 dut (
    .clk         (clk),
    .reset       (reset),
    .in1         (in1),
    .truncated_in(truncated_in),
    .start       (start),
    .result      (result),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [40:0] mk(input logic sgn, input int scale,
                                     input logic [28:0] frac,
                                     input logic inf, input logic zero);
    return {sgn, 9'(scale), frac, inf, zero};
  endfunction

  logic [40:0] v_in  [NV];
  logic        v_tr  [NV];
  logic [31:0] v_exp [NV];

  logic [16:0] gap_pat;
  logic        exp_vld [64];
  logic [31:0] exp_res [64];

  initial begin
    v_in[0]  = mk(0, 0,    29'h0,       0, 0); v_tr[0]  = 0; v_exp[0]  = 32'h40000000;
    v_in[1]  = mk(1, 0,    29'h0,       0, 0); v_tr[1]  = 0; v_exp[1]  = 32'hC0000000;
    v_in[2]  = mk(0, 1,    29'h0,       0, 0); v_tr[2]  = 0; v_exp[2]  = 32'h44000000;
    v_in[3]  = mk(1, 77,   29'h1234567, 0, 1); v_tr[3]  = 1; v_exp[3]  = 32'h00000000;
    v_in[4]  = mk(1, 5,    29'h55,      1, 1); v_tr[4]  = 0; v_exp[4]  = 32'h80000000;
    v_in[5]  = mk(0, 250,  29'h0,       0, 0); v_tr[5]  = 0; v_exp[5]  = 32'h7FFFFFFF;
    v_in[6]  = mk(0, -250, 29'h0,       0, 0); v_tr[6]  = 0; v_exp[6]  = 32'h00000001;
    v_in[7]  = mk(1, -250, 29'h0,       0, 0); v_tr[7]  = 0; v_exp[7]  = 32'hFFFFFFFF;
    v_in[8]  = mk(0, 0,    29'h4,       0, 0); v_tr[8]  = 0; v_exp[8]  = 32'h40000000;
    v_in[9]  = mk(0, 0,    29'h4,       0, 0); v_tr[9]  = 1; v_exp[9]  = 32'h40000001;
    v_in[10] = mk(0, 0,    29'hC,       0, 0); v_tr[10] = 0; v_exp[10] = 32'h40000002;
    v_in[11] = mk(0, -1,   29'h0,       0, 0); v_tr[11] = 0; v_exp[11] = 32'h3C000000;
    v_in[12] = mk(0, 239,  29'h0,       0, 0); v_tr[12] = 0; v_exp[12] = 32'h7FFFFFFF;
    v_in[13] = mk(0, -232, 29'h0,       0, 0); v_tr[13] = 0; v_exp[13] = 32'h00000002;
    v_in[14] = mk(1, 0,    29'hC,       0, 0); v_tr[14] = 0; v_exp[14] = 32'hBFFFFFFE;
    v_in[15] = mk(0, 240,  29'h0,       0, 0); v_tr[15] = 0; v_exp[15] = 32'h7FFFFFFF;
    v_in[16] = mk(0, 2,    29'h10000000, 0, 0); v_tr[16] = 0; v_exp[16] = 32'h4A000000;
  end

  initial begin
    int idx;
    int n_done;
    logic [31:0] last;
    logic        iss;

    reset = 1'b1; start = 1'b0; in1 = '0; truncated_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_result", result, 32'h0);

    // 8 back-to-back starts, then the rest with gaps.
    gap_pat = 17'b1_1010_0011_1010_0110;
    idx = 0; n_done = 0; last = 32'h0;
    for (int c = 0; c < 29; c++) begin
      @(posedge clk);
      #1;
      if (c < 8) iss = 1'b1;
      else if (c - 8 < 17) iss = gap_pat[c-8];
      else iss = 1'b0;
      if (idx >= NV) iss = 1'b0;
      exp_vld[c] = iss;
      exp_res[c] = iss ? v_exp[idx] : 32'h0;
      start = iss;
      if (iss) begin
        in1 = v_in[idx]; truncated_in = v_tr[idx]; idx++;
      end else begin
        in1 = 41'($urandom()) ^ {9'h0, 32'($urandom())}; truncated_in = 1'($urandom());
      end
      @(negedge clk);
      if (c >= 3) begin
        chk($sformatf("done_c%0d", c), {31'b0, done}, {31'b0, exp_vld[c-3]});
        if (exp_vld[c-3]) begin
          chk($sformatf("res_c%0d", c), result, exp_res[c-3]);
          last = exp_res[c-3];
        end else if (n_done > 0) begin
          chk($sformatf("hold_c%0d", c), result, last);
        end
        if (done) n_done++;
      end
    end
    chk("issued", 32'(idx), 32'(NV));
    chk("done_count", 32'(n_done), 32'(NV));

    // Two starts in flight, then reset (with a start on the reset edge).
    @(posedge clk); #1 start = 1'b1; in1 = v_in[0]; truncated_in = 1'b0;
    @(posedge clk); #1 start = 1'b1; in1 = v_in[1];
    @(posedge clk); #1 start = 1'b1; in1 = v_in[2]; reset = 1'b1;
    @(posedge clk); #1 start = 1'b0; reset = 1'b0;
    @(negedge clk);
    chk("flush_done", {31'b0, done}, 32'h0);
    chk("flush_result", result, 32'h0);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk($sformatf("flush_done_%0d", j), {31'b0, done}, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
